// File: rtl/pic_data_buffer.sv
// pic_data_buffer: bidirectional data bus buffer of an 8259-style PIC.
// Captures D for the internal logic, drives status/vector back out, tri-states otherwise.
module pic_data_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] D,
    input  logic              R,
    input  logic              W,
    input  logic              Flag_From_Cascade,
    input  logic [DATA_W-1:0] InternalData_in,
    output logic [DATA_W-1:0] InternalData_out,
    output logic              data_valid,
    output logic              bus_conflict
);

    typedef enum logic [1:0] {
        M_IDLE,
        M_CAPTURE,
        M_DRIVE,
        M_CONFLICT
    } mode_t;

    mode_t             w_mode;
    logic              w_ctrl_known;
    logic              w_capture;
    logic              w_drive;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_prev_capture;

    // Unknown control lines fall back to IDLE so the bus is never driven on garbage.
    assign w_ctrl_known = !$isunknown({R, W, Flag_From_Cascade});

    always_comb
        w_mode = !w_ctrl_known                 ? M_IDLE     :
                 (Flag_From_Cascade || (!R && W)) ? M_CAPTURE  :
                 (R && !W)                     ? M_DRIVE    :
                 (!R && !W)                    ? M_CONFLICT : M_IDLE;

    assign w_capture    = w_mode == M_CAPTURE;
    assign w_drive      = w_mode == M_DRIVE;
    assign bus_conflict = w_mode == M_CONFLICT;

    assign D = (w_drive && !reset) ? InternalData_in : {DATA_W{1'bz}};

    // data_valid marks only the first capture edge of each capture window.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_prev_capture <= 1'b0;
        end else begin
            r_prev_capture <= w_capture;
            r_valid        <= w_capture && !r_prev_capture;
            if (w_capture)
                r_data <= D;
        end

    assign InternalData_out = r_data;
    assign data_valid       = r_valid;

endmodule

// File: tb/tb_pic_data_buffer.sv
// tb_pic_data_buffer: directed test-plan checks plus randomized traffic scored against
// a mode-table model of the buffer.
module tb_pic_data_buffer;

    localparam int CAP  = 0;
    localparam int DRV  = 1;
    localparam int CONF = 2;
    localparam int IDLE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       R = 1'b1;
    logic       W = 1'b0;
    logic       F = 1'b0;
    logic [7:0] din = 8'h5A;
    logic [7:0] tb_d = 8'hC3;
    logic       tb_en;
    wire  [7:0] d_bus;
    logic [7:0] dout;
    logic       dvalid;
    logic       conflict;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_out = 8'h00;
    logic       m_valid = 1'b0;
    int         m_run = 0;

    always #5 clk = ~clk;

    function automatic int mode_of(input logic r, input logic w, input logic f);
        if (f || (!r && w)) return CAP;
        if (r && !w) return DRV;
        if (!r && !w) return CONF;
        return IDLE;
    endfunction

    // The bench owns D whenever the DUT must not drive it, so any stray DUT drive shows as contention.
    assign tb_en = !(mode_of(R, W, F) == DRV && !reset);
    assign d_bus = tb_en ? tb_d : 8'hzz;

    pic_data_buffer #(.DATA_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .D(d_bus),
        .R(R),
        .W(W),
        .Flag_From_Cascade(F),
        .InternalData_in(din),
        .InternalData_out(dout),
        .data_valid(dvalid),
        .bus_conflict(conflict)
    );

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    // Model: count consecutive capture edges; valid only on the first one of a window.
    always @(posedge clk or posedge reset)
        if (reset) begin
            m_out   = 8'h00;
            m_valid = 1'b0;
            m_run   = 0;
        end else if (mode_of(R, W, F) == CAP) begin
            m_out   = d_bus;
            m_run   = m_run + 1;
            m_valid = (m_run == 1);
        end else begin
            m_run   = 0;
            m_valid = 1'b0;
        end

    always @(negedge clk) begin
        chk("m_out", dout, m_out);
        chk("m_valid", {7'b0, dvalid}, {7'b0, m_valid});
        chk("m_conflict", {7'b0, conflict}, {7'b0, mode_of(R, W, F) == CONF});
        chk("m_bus", d_bus, (mode_of(R, W, F) == DRV && !reset) ? din : tb_d);
    end

    initial begin
        at_neg;
        at_neg;
        chk("rst_bus", d_bus, 8'hC3);
        chk("rst_out", dout, 8'h00);
        chk("rst_valid", {7'b0, dvalid}, 8'h00);
        reset = 1'b0;
        #1 chk("rel_bus", d_bus, 8'h5A);

        @(posedge clk); #1;
        R = 1'b0; W = 1'b1; din = 8'h00; tb_d = 8'hFF;
        at_neg;
        chk("cap_bus", d_bus, 8'hFF);
        chk("cap_pre", dout, 8'h00);
        at_neg;
        chk("cap_out", dout, 8'hFF);
        chk("cap_valid", {7'b0, dvalid}, 8'h01);
        at_neg;
        chk("cap_valid2", {7'b0, dvalid}, 8'h00);

        @(posedge clk); #1;
        R = 1'b1; W = 1'b1;
        @(posedge clk); #1;
        F = 1'b1; R = 1'b1; W = 1'b0; tb_d = 8'hAA; din = 8'h55;
        at_neg;
        chk("casc_bus", d_bus, 8'hAA);
        at_neg;
        chk("casc_out", dout, 8'hAA);
        chk("casc_valid", {7'b0, dvalid}, 8'h01);

        @(posedge clk); #1;
        F = 1'b0; din = 8'h3C;
        #1 chk("drv_bus", d_bus, 8'h3C);
        at_neg;
        chk("drv_out", dout, 8'hAA);
        chk("drv_valid", {7'b0, dvalid}, 8'h00);

        @(posedge clk); #1;
        R = 1'b0; W = 1'b0; tb_d = 8'h99; din = 8'h66;
        #1 chk("conf_flag", {7'b0, conflict}, 8'h01);
        chk("conf_bus", d_bus, 8'h99);
        at_neg;
        chk("conf_out", dout, 8'hAA);

        @(posedge clk); #1;
        R = 1'b1; W = 1'b1; tb_d = 8'h77;
        #1 chk("idle_flag", {7'b0, conflict}, 8'h00);
        at_neg;
        chk("idle_out", dout, 8'hAA);

        @(posedge clk); #1;
        R = 1'b0; W = 1'b1; tb_d = 8'h11; din = 8'hEE;
        at_neg;
        at_neg;
        chk("mid_cap", dout, 8'h11);
        reset = 1'b1; tb_d = 8'h22;
        #1 chk("mid_rst_out", dout, 8'h00);
        chk("mid_rst_valid", {7'b0, dvalid}, 8'h00);
        at_neg;
        reset = 1'b0;
        at_neg;
        chk("mid_rel_out", dout, 8'h22);
        chk("mid_rel_valid", {7'b0, dvalid}, 8'h01);
        at_neg;
        chk("mid_rel_valid2", {7'b0, dvalid}, 8'h00);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            R     = 1'($urandom_range(0, 1));
            W     = 1'($urandom_range(0, 1));
            F     = ($urandom_range(0, 4) == 0);
            tb_d  = 8'($urandom);
            din   = ~tb_d;
            reset = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        at_neg;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pic_data_buffer.md
Name: pic_data_buffer

Overview:
- Bidirectional 8-bit data bus buffer of the 8259-style programmable interrupt controller.
- Sits between the external system data bus D and the controller's internal data bus.
- Captures bus data into a register for the internal logic (control-word and cascade transfers).
- Drives internal data (status or vector) onto D when the bus is turned around.
- Tri-states D at all other times.

Parameters:
- DATA_W, 8, width of the external and internal data buses.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- D  inout  DATA_W  external system data bus.
- R  input  1  bus read-side control (see mode table).
- W  input  1  bus write-side control (see mode table).
- Flag_From_Cascade  input  1  cascade transfer request; forces capture mode.
- InternalData_in  input  DATA_W  internal data to be driven onto D.
- InternalData_out  output  DATA_W  registered copy of the last captured D value.
- data_valid  output  1  one-cycle pulse marking the first capture of a capture window.
- bus_conflict  output  1  high while R=0 and W=0 simultaneously.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Mode decode is combinational, evaluated in priority order:
  - CAPTURE: Flag_From_Cascade=1, or (R=0 and W=1).
  - DRIVE: R=1, W=0, Flag_From_Cascade=0.
  - CONFLICT: R=0, W=0, Flag_From_Cascade=0.
  - IDLE: R=1, W=1, Flag_From_Cascade=0.
  - Any X/Z on R, W or Flag_From_Cascade is treated as IDLE.
- D drive:
  - D = InternalData_in only in DRIVE mode, combinationally (zero latency).
  - D = high-Z in every other mode.
  - D = high-Z during reset.
  - The block never drives D in CAPTURE mode, so the external master owns the bus then.
- Capture register:
  - On each rising clk edge in CAPTURE mode, InternalData_out <= D.
  - In all other modes, InternalData_out holds its value.
  - Latency: D to InternalData_out is 1 clock.
  - Reset value: 8'h00.
- data_valid:
  - Registered.
  - Goes 1 for exactly one cycle on the first capture edge after entering CAPTURE from any other mode (tracked by a registered previous-mode flag).
  - Stays 0 on subsequent edges while CAPTURE persists.
  - Reset value: 0.
  - Asserting reset mid-window clears it. If CAPTURE is still active after reset deasserts, the first edge pulses data_valid again.
- bus_conflict:
  - Combinational, 1 only in CONFLICT mode.
  - In CONFLICT, D stays high-Z and no capture occurs.
  - Reset does not mask it.
- Simultaneous Flag_From_Cascade=1 with R=1, W=0: CAPTURE wins; D stays high-Z; no drive contention.
- Mode changes take effect on D in the same delta (no registered output enable). Bus turnaround timing is the responsibility of the bus masters.
- X/Z on D while capturing is stored as-is; no filtering.

Test Plan:
- Reset: assert reset=1 with R=1, W=0, InternalData_in=8'h5A -> D=8'hZZ, InternalData_out=8'h00, data_valid=0. Release reset -> D=8'h5A immediately.
- Capture: R=0, W=1, bench drives D=8'hFF -> InternalData_out=8'hFF one clk after; data_valid pulses for 1 cycle only; DUT never drives D.
- Cascade priority: Flag_From_Cascade=1, R=1, W=0, bench drives D=8'hAA -> no contention (D resolves to 8'hAA), InternalData_out=8'hAA next edge, data_valid pulses.
- Drive/hold: R=1, W=0, Flag=0, InternalData_in=8'h3C -> D=8'h3C with zero latency; InternalData_out holds the previous value (8'hAA).
- Conflict/idle: R=0, W=0 -> bus_conflict=1, D=Z, InternalData_out unchanged. R=1, W=1 -> bus_conflict=0, D=Z, no capture.
- Reset mid-window: capture 8'h11, assert reset while R=0, W=1 -> InternalData_out=8'h00 asynchronously. Release with D=8'h22 -> 8'h22 next edge, data_valid pulses once.
